vga_sync_gen: RTL and testbench

- Sits directly downstream of the free-running VGA column/row counter and upstream of the VGA pins.
- Decodes i_Col_Count/i_Row_Count into HSync, VSync and the active-video window.
- Delays sync/active by a parameterised number of cycles so they line up with RGB from a pipelined pattern generator.
- Blanks RGB outside the active area; produces a frame-start strobe and a sticky counter-consistency error flag.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_sync_gen.sv | 134 +++++++++++++
 tb/tb_vga_sync_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants shared by the VGA counter and the
// sync generator, plus the bundle type carried through the alignment delay line.
package vga_timing_pkg;

  localparam int VGA_COUNT_WIDTH   = 10;
  localparam int VGA_TOTAL_COLS    = 800;
  localparam int VGA_TOTAL_ROWS    = 525;
  localparam int VGA_ACTIVE_COLS   = 640;
  localparam int VGA_ACTIVE_ROWS   = 480;
  localparam int VGA_H_FRONT_PORCH = 16;
  localparam int VGA_H_SYNC_PULSE  = 96;
  localparam int VGA_V_FRONT_PORCH = 10;
  localparam int VGA_V_SYNC_PULSE  = 2;

  // Raw (active-high) timing decode for one pixel position
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic fs;
  } sync_bits_t;

  // True when value lies in the inclusive window [first, last]
  function automatic logic in_window(input logic [VGA_COUNT_WIDTH-1:0] value,
                                     input logic [VGA_COUNT_WIDTH-1:0] first,
                                     input logic [VGA_COUNT_WIDTH-1:0] last);
    return (value >= first) && (value <= last);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH-bit shift register of DEPTH stages with synchronous clear.
// DEPTH=0 degenerates to a wire so the caller never needs a special case.
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = i_Clk ^ i_Rst;
      assign o_Data = i_Data;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      // Advance one stage per clock; reset empties every stage to zero
      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
          stages[0] <= i_Data;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign o_Data = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: decodes the free-running column/row counts into sync and active
// video, delays them to meet RGB from a pipelined pattern generator, blanks RGB
// outside the visible area and watches the counter for inconsistent steps.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS      = VGA_TOTAL_COLS,
  parameter int TOTAL_ROWS      = VGA_TOTAL_ROWS,
  parameter int ACTIVE_COLS     = VGA_ACTIVE_COLS,
  parameter int ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH   = VGA_H_FRONT_PORCH,
  parameter int H_SYNC_PULSE    = VGA_H_SYNC_PULSE,
  parameter int V_FRONT_PORCH   = VGA_V_FRONT_PORCH,
  parameter int V_SYNC_PULSE    = VGA_V_SYNC_PULSE,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int VIDEO_WIDTH     = 3,
  parameter int RGB_DELAY       = 2
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic [VGA_COUNT_WIDTH-1:0] i_Col_Count,
  input  logic [VGA_COUNT_WIDTH-1:0] i_Row_Count,
  input  logic [VIDEO_WIDTH-1:0]     i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0]     i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0]     i_Blu_Video,
  output logic                       o_HSync,
  output logic                       o_VSync,
  output logic [VIDEO_WIDTH-1:0]     o_Red_Video,
  output logic [VIDEO_WIDTH-1:0]     o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0]     o_Blu_Video,
  output logic                       o_Active,
  output logic                       o_Frame_Start,
  output logic                       o_Count_Error
);

  localparam int CW = VGA_COUNT_WIDTH;

  localparam logic [CW-1:0] ACTIVE_COLS_C = CW'(ACTIVE_COLS);
  localparam logic [CW-1:0] ACTIVE_ROWS_C = CW'(ACTIVE_ROWS);
  localparam logic [CW-1:0] TOTAL_COLS_C  = CW'(TOTAL_COLS);
  localparam logic [CW-1:0] TOTAL_ROWS_C  = CW'(TOTAL_ROWS);
  localparam logic [CW-1:0] LAST_COL      = CW'(TOTAL_COLS - 1);
  localparam logic [CW-1:0] LAST_ROW      = CW'(TOTAL_ROWS - 1);
  localparam logic [CW-1:0] H_SYNC_FIRST  = CW'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CW-1:0] H_SYNC_LAST   = CW'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_PULSE - 1);
  localparam logic [CW-1:0] V_SYNC_FIRST  = CW'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [CW-1:0] V_SYNC_LAST   = CW'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE - 1);
  localparam logic [CW-1:0] COUNT_ONE     = CW'(1);

  // Deasserted sync level; XOR with it turns raw sync into pin polarity
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  // Count monitor states
  localparam logic [0:0] MON_FIRST = 1'b0;
  localparam logic [0:0] MON_TRACK = 1'b1;

  sync_bits_t decoded;
  sync_bits_t aligned;

  logic [0:0]    mon_state;
  logic [CW-1:0] prev_col;
  logic [CW-1:0] prev_row;
  logic [CW-1:0] exp_col;
  logic [CW-1:0] exp_row;
  logic          count_bad;

  // Decode the incoming counts into raw active-high timing bits
  always_comb begin
    decoded.active = (i_Col_Count < ACTIVE_COLS_C) && (i_Row_Count < ACTIVE_ROWS_C);
    decoded.hs     = in_window(i_Col_Count, H_SYNC_FIRST, H_SYNC_LAST);
    decoded.vs     = in_window(i_Row_Count, V_SYNC_FIRST, V_SYNC_LAST);
    decoded.fs     = (i_Col_Count == '0) && (i_Row_Count == '0);
  end

  vga_delay_line #(
    .WIDTH ($bits(sync_bits_t)),
    .DEPTH (RGB_DELAY)
  ) u_align (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Data (decoded),
    .o_Data (aligned)
  );

  // Register the pins: polarity applied to sync, RGB gated by the aligned active bit
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_HSync       <= SYNC_IDLE;
      o_VSync       <= SYNC_IDLE;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Red_Video   <= '0;
      o_Grn_Video   <= '0;
      o_Blu_Video   <= '0;
    end else begin
      o_HSync       <= aligned.hs ^ SYNC_IDLE;
      o_VSync       <= aligned.vs ^ SYNC_IDLE;
      o_Active      <= aligned.active;
      o_Frame_Start <= aligned.fs;
      o_Red_Video   <= aligned.active ? i_Red_Video : '0;
      o_Grn_Video   <= aligned.active ? i_Grn_Video : '0;
      o_Blu_Video   <= aligned.active ? i_Blu_Video : '0;
    end
  end

  // Predict the next count pair from the previous one and flag any disagreement
  always_comb begin
    exp_col = prev_col + COUNT_ONE;
    exp_row = prev_row;
    if (prev_col == LAST_COL) begin
      exp_col = '0;
      exp_row = (prev_row == LAST_ROW) ? '0 : prev_row + COUNT_ONE;
    end
    count_bad = (i_Col_Count != exp_col) || (i_Row_Count != exp_row) ||
                (i_Col_Count >= TOTAL_COLS_C) || (i_Row_Count >= TOTAL_ROWS_C);
  end

  // First cycle after reset only captures; afterwards every step is checked and
  // the history always follows the live counts so one glitch flags only once
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      mon_state     <= MON_FIRST;
      prev_col      <= '0;
      prev_row      <= '0;
      o_Count_Error <= 1'b0;
    end else begin
      mon_state <= MON_TRACK;
      prev_col  <= i_Col_Count;
      prev_row  <= i_Row_Count;
      if ((mon_state == MON_TRACK) && count_bad) o_Count_Error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: drives three sync generators (RGB_DELAY 2/0/5, one with
// active-high sync) from a shared column/row stream and checks timing, blanking,
// frame start and the count monitor against hand-derived values.
module tb_vga_sync_gen;

  localparam int NDUT = 3;
  localparam int DLY [NDUT] = '{2, 0, 5};
  localparam int SAL [NDUT] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] col_in;
  logic [9:0] row_in;
  logic [2:0] red_in [NDUT];
  logic [2:0] grn_in [NDUT];
  logic [2:0] blu_in [NDUT];

  logic [NDUT-1:0] hs_out;
  logic [NDUT-1:0] vs_out;
  logic [NDUT-1:0] act_out;
  logic [NDUT-1:0] fs_out;
  logic [NDUT-1:0] err_out;
  logic [2:0] red_out [NDUT];
  logic [2:0] grn_out [NDUT];
  logic [2:0] blu_out [NDUT];

  int checks = 0;
  int failures = 0;

  logic [9:0] hist_col [8];
  logic [9:0] hist_row [8];
  logic       hist_val [8];
  logic [9:0] cur_col;
  logic [9:0] cur_row;
  logic       exp_err;
  logic       collect;

  int hs_count [NDUT];
  int hs_first [NDUT];
  int vs_count [NDUT];
  int vs_first_row [NDUT];
  int fs_count [NDUT];
  int mark639 [NDUT];
  int mark640 [NDUT];
  int act_bad [NDUT];
  int hs_bad [NDUT];
  int vs_bad [NDUT];
  int fs_bad [NDUT];
  int rgb_bad [NDUT];
  int err_bad [NDUT];

  always #5 clk = ~clk;

  vga_sync_gen #(.SYNC_ACTIVE_LOW(1), .RGB_DELAY(2)) u_dut_d2 (
    .i_Clk(clk), .i_Rst(rst), .i_Col_Count(col_in), .i_Row_Count(row_in),
    .i_Red_Video(red_in[0]), .i_Grn_Video(grn_in[0]), .i_Blu_Video(blu_in[0]),
    .o_HSync(hs_out[0]), .o_VSync(vs_out[0]),
    .o_Red_Video(red_out[0]), .o_Grn_Video(grn_out[0]), .o_Blu_Video(blu_out[0]),
    .o_Active(act_out[0]), .o_Frame_Start(fs_out[0]), .o_Count_Error(err_out[0]));

  vga_sync_gen #(.SYNC_ACTIVE_LOW(0), .RGB_DELAY(0)) u_dut_d0 (
    .i_Clk(clk), .i_Rst(rst), .i_Col_Count(col_in), .i_Row_Count(row_in),
    .i_Red_Video(red_in[1]), .i_Grn_Video(grn_in[1]), .i_Blu_Video(blu_in[1]),
    .o_HSync(hs_out[1]), .o_VSync(vs_out[1]),
    .o_Red_Video(red_out[1]), .o_Grn_Video(grn_out[1]), .o_Blu_Video(blu_out[1]),
    .o_Active(act_out[1]), .o_Frame_Start(fs_out[1]), .o_Count_Error(err_out[1]));

  vga_sync_gen #(.SYNC_ACTIVE_LOW(1), .RGB_DELAY(5)) u_dut_d5 (
    .i_Clk(clk), .i_Rst(rst), .i_Col_Count(col_in), .i_Row_Count(row_in),
    .i_Red_Video(red_in[2]), .i_Grn_Video(grn_in[2]), .i_Blu_Video(blu_in[2]),
    .o_HSync(hs_out[2]), .o_VSync(vs_out[2]),
    .o_Red_Video(red_out[2]), .o_Grn_Video(grn_out[2]), .o_Blu_Video(blu_out[2]),
    .o_Active(act_out[2]), .o_Frame_Start(fs_out[2]), .o_Count_Error(err_out[2]));

  // Pattern generator colours for a given column (marker 5 at column 639)
  function automatic logic [2:0] red_for(input logic [9:0] c);
    return (c == 10'd639) ? 3'd5 : 3'd7;
  endfunction

  function automatic logic [2:0] blu_for(input logic [9:0] c);
    return c[2:0];
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Score every DUT output after an edge against the counts it should reflect
  task automatic scoreCycle();
    for (int j = 0; j < NDUT; j++) begin
      logic [9:0] tc;
      logic [9:0] tr;
      logic       v;
      logic       e_act, e_hs, e_vs, e_fs, lvl, hs_on, vs_on;
      logic [2:0] e_red, e_grn, e_blu;
      tc = hist_col[DLY[j]];
      tr = hist_row[DLY[j]];
      v  = hist_val[DLY[j]];
      e_act = v && (tc < 10'd640) && (tr < 10'd480);
      e_hs  = v && (tc >= 10'd656) && (tc <= 10'd751);
      e_vs  = v && (tr >= 10'd490) && (tr <= 10'd491);
      e_fs  = v && (tc == 10'd0) && (tr == 10'd0);
      e_red = e_act ? red_for(tc) : 3'd0;
      e_grn = e_act ? 3'd6 : 3'd0;
      e_blu = e_act ? blu_for(tc) : 3'd0;
      lvl   = (SAL[j] != 0) ? 1'b0 : 1'b1;
      hs_on = (hs_out[j] == lvl);
      vs_on = (vs_out[j] == lvl);
      if (act_out[j] != e_act) act_bad[j]++;
      if (hs_on != e_hs) hs_bad[j]++;
      if (vs_on != e_vs) vs_bad[j]++;
      if (fs_out[j] != e_fs) fs_bad[j]++;
      if ((red_out[j] != e_red) || (grn_out[j] != e_grn) || (blu_out[j] != e_blu)) rgb_bad[j]++;
      if (err_out[j] != exp_err) err_bad[j]++;
      if (collect) begin
        if (v && (tr == 10'd489) && hs_on) begin
          if (hs_count[j] == 0) hs_first[j] = int'(tc);
          hs_count[j]++;
        end
        if (vs_on) begin
          if (vs_count[j] == 0) vs_first_row[j] = int'(tr);
          vs_count[j]++;
        end
        if (fs_out[j]) fs_count[j]++;
        if (v && (tr == 10'd0) && (tc == 10'd639)) mark639[j] = int'(red_out[j]);
        if (v && (tr == 10'd0) && (tc == 10'd640)) mark640[j] = int'(red_out[j]);
      end
    end
  endtask

  // Drive one cycle of counts (and delayed RGB per DUT), clock it, then score
  task automatic applyStimulus(input logic [9:0] c, input logic [9:0] r, input logic reset_now);
    for (int i = 7; i > 0; i--) begin
      hist_col[i] = hist_col[i-1];
      hist_row[i] = hist_row[i-1];
      hist_val[i] = hist_val[i-1];
    end
    hist_col[0] = c;
    hist_row[0] = r;
    hist_val[0] = !reset_now;
    if (reset_now) for (int i = 0; i < 8; i++) hist_val[i] = 1'b0;
    rst    = reset_now;
    col_in = c;
    row_in = r;
    for (int j = 0; j < NDUT; j++) begin
      red_in[j] = red_for(hist_col[DLY[j]]);
      grn_in[j] = 3'd6;
      blu_in[j] = blu_for(hist_col[DLY[j]]);
    end
    @(posedge clk);
    #1;
    scoreCycle();
  endtask

  task automatic advanceCounter();
    if (cur_col == 10'd799) begin
      cur_col = 10'd0;
      cur_row = (cur_row == 10'd524) ? 10'd0 : cur_row + 10'd1;
    end else begin
      cur_col = cur_col + 10'd1;
    end
  endtask

  task automatic runFor(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(cur_col, cur_row, 1'b0);
      advanceCounter();
    end
  endtask

  // Run the counter until the given position is next to be driven
  task automatic runUntil(input string tag, input logic [9:0] c, input logic [9:0] r);
    int guard;
    guard = 0;
    while (!((cur_col == c) && (cur_row == r)) && (guard < 50000)) begin
      applyStimulus(cur_col, cur_row, 1'b0);
      advanceCounter();
      guard++;
    end
    checkOutput(tag, int'((cur_col == c) && (cur_row == r)), 1);
  endtask

  initial begin
    rst = 1'b1;
    col_in = '0;
    row_in = '0;
    exp_err = 1'b0;
    collect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hist_col[i] = '0;
      hist_row[i] = '0;
      hist_val[i] = 1'b0;
    end
    for (int j = 0; j < NDUT; j++) begin
      red_in[j] = '0; grn_in[j] = '0; blu_in[j] = '0;
      hs_count[j] = 0; hs_first[j] = -1; vs_count[j] = 0; vs_first_row[j] = -1;
      fs_count[j] = 0; mark639[j] = 0; mark640[j] = 7;
      act_bad[j] = 0; hs_bad[j] = 0; vs_bad[j] = 0; fs_bad[j] = 0; rgb_bad[j] = 0; err_bad[j] = 0;
    end

    // Reset with the counter parked just above the vertical sync rows
    applyStimulus(10'd0, 10'd489, 1'b1);
    applyStimulus(10'd0, 10'd489, 1'b1);
    checkOutput("rst_hsync_low_pol", int'(hs_out[0]), 1);
    checkOutput("rst_vsync_low_pol", int'(vs_out[0]), 1);
    checkOutput("rst_hsync_high_pol", int'(hs_out[1]), 0);
    checkOutput("rst_vsync_high_pol", int'(vs_out[1]), 0);
    checkOutput("rst_red", int'(red_out[0]), 0);
    checkOutput("rst_active", int'(act_out[0]), 0);
    checkOutput("rst_frame_start", int'(fs_out[0]), 0);
    checkOutput("rst_count_error", int'(err_out[0]), 0);

    // Free run from row 489 through the frame wrap into row 1
    cur_col = 10'd0;
    cur_row = 10'd489;
    collect = 1'b1;
    runFor(29700);
    collect = 1'b0;

    // Reset mid-frame at row 200 col 300 while the counter keeps running
    cur_col = 10'd296;
    cur_row = 10'd199;
    applyStimulus(cur_col, cur_row, 1'b1);
    advanceCounter();
    runUntil("reach_r200_c300", 10'd300, 10'd200);
    applyStimulus(cur_col, cur_row, 1'b1);
    advanceCounter();
    checkOutput("midrst_hsync", int'(hs_out[0]), 1);
    checkOutput("midrst_vsync", int'(vs_out[0]), 1);
    checkOutput("midrst_red", int'(red_out[0]), 0);
    checkOutput("midrst_active", int'(act_out[0]), 0);
    checkOutput("midrst_d0_active", int'(act_out[1]), 0);
    runFor(1);
    checkOutput("d2_refill_edge1", int'(act_out[0]), 0);
    checkOutput("d0_resume_edge1", int'(act_out[1]), 1);
    runFor(1);
    checkOutput("d2_refill_edge2", int'(act_out[0]), 0);
    runFor(1);
    checkOutput("d2_resume_edge3", int'(act_out[0]), 1);
    checkOutput("d2_resume_red", int'(red_out[0]), 7);

    // Column jump 100 -> 102 must latch the error on that edge
    runUntil("reach_r201_c101", 10'd101, 10'd201);
    checkOutput("err_before_jump", int'(err_out[0]), 0);
    cur_col = 10'd102;
    exp_err = 1'b1;
    runFor(1);
    for (int j = 0; j < NDUT; j++)
      checkOutput($sformatf("err_after_jump_d%0d", DLY[j]), int'(err_out[j]), 1);
    runFor(50);
    cur_col = 10'd790;
    cur_row = 10'd524;
    runFor(30);
    checkOutput("err_sticky_frame", int'(err_out[0]), 1);
    exp_err = 1'b0;
    applyStimulus(cur_col, cur_row, 1'b1);
    checkOutput("err_cleared_d2", int'(err_out[0]), 0);
    checkOutput("err_cleared_d5", int'(err_out[2]), 0);

    // Consistent steps on an out-of-range row are still an error
    applyStimulus(10'd5, 10'd530, 1'b1);
    applyStimulus(10'd5, 10'd530, 1'b0);
    checkOutput("range_first_nocheck", int'(err_out[0]), 0);
    exp_err = 1'b1;
    applyStimulus(10'd6, 10'd530, 1'b0);
    checkOutput("range_row_error", int'(err_out[0]), 1);
    for (int i = 7; i < 14; i++) applyStimulus(10'(i), 10'd530, 1'b0);

    for (int j = 0; j < NDUT; j++) begin
      checkOutput($sformatf("d%0d_hs_width", DLY[j]), hs_count[j], 96);
      checkOutput($sformatf("d%0d_hs_first_col", DLY[j]), hs_first[j], 656);
      checkOutput($sformatf("d%0d_vs_cycles", DLY[j]), vs_count[j], 1600);
      checkOutput($sformatf("d%0d_vs_first_row", DLY[j]), vs_first_row[j], 490);
      checkOutput($sformatf("d%0d_fs_pulses", DLY[j]), fs_count[j], 1);
      checkOutput($sformatf("d%0d_marker_col639", DLY[j]), mark639[j], 5);
      checkOutput($sformatf("d%0d_blank_col640", DLY[j]), mark640[j], 0);
      checkOutput($sformatf("d%0d_active_bad_cycles", DLY[j]), act_bad[j], 0);
      checkOutput($sformatf("d%0d_hsync_bad_cycles", DLY[j]), hs_bad[j], 0);
      checkOutput($sformatf("d%0d_vsync_bad_cycles", DLY[j]), vs_bad[j], 0);
      checkOutput($sformatf("d%0d_fs_bad_cycles", DLY[j]), fs_bad[j], 0);
      checkOutput($sformatf("d%0d_rgb_bad_cycles", DLY[j]), rgb_bad[j], 0);
      checkOutput($sformatf("d%0d_err_bad_cycles", DLY[j]), err_bad[j], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
